fib_seq_gen: RTL
================

Name: fib_seq_gen

Overview:
Parametrised, stream-output generalised Fibonacci sequence generator. Software or a controller loads two seed terms and a term count, then pulses start. The block streams terms over a valid/ready interface with index, last-beat marker and overflow flags, and pulses done when finished. It serves as the reusable sequence source for datapath test harnesses. It replaces free-running, unbounded generators with a bounded, back-pressurable, fixed-storage design (two term registers, no history buffer).

Parameters:
WIDTH, 32, bit width of seeds, terms and adder (arithmetic modulo 2^WIDTH)
CNT_W, 16, bit width of num_terms and out_idx

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request a new sequence; accepted only in IDLE
seed0  in  WIDTH  term 0, sampled on accepted start
seed1  in  WIDTH  term 1, sampled on accepted start
num_terms  in  CNT_W  number of terms to emit, sampled on accepted start; 0 allowed
busy  out  1  high in RUN and DONE states
out_valid  out  1  term presented
out_ready  in  1  consumer accepts term
out_data  out  WIDTH  current term value
out_idx  out  CNT_W  index k of current term, starting at 0
out_last  out  1  high with the term whose idx == num_terms-1
out_ovf  out  1  this term's addition carried out of WIDTH bits
ovf_sticky  out  1  any emitted term overflowed since last accepted start
done  out  1  single-cycle completion pulse

Behaviour:
- Reset: the rising edge with rst=1 forces state IDLE. Over that edge, busy, out_valid, out_data, out_idx, out_last, out_ovf, ovf_sticky and done all go to 0.
- rst mid-sequence aborts the sequence; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE + start=1 at edge t:
  - Latch seeds and num_terms; clear ovf_sticky.
  - If num_terms==0: go to DONE. done=1 for the cycle after t, with no beat.
  - Otherwise: go to RUN. Starting the cycle after t: out_valid=1, out_data=seed0, out_idx=0, out_ovf=0, out_last=(num_terms==1).
- start while busy is ignored; latched values do not change.
- Handshake: a beat transfers on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_idx, out_last and out_ovf hold stable.
  - out_valid does not drop until the beat transfers.
- Advance (no bubbles): on the transfer edge of a non-last beat k, the next cycle presents beat k+1:
  - term1 = seed1, out_ovf=0.
  - term k+1 for k>=1 = (term k-1 + term k) mod 2^WIDTH.
  - out_ovf = carry out of that WIDTH-bit add, computed on the stored (already wrapped) terms.
- ovf_sticky sets in the same cycle an out_ovf=1 beat is presented. It holds until the next accepted start or reset.
- Last beat: on its transfer edge, out_valid drops and the FSM enters DONE. done=1 for exactly the following cycle, then the FSM returns to IDLE.
- start asserted during the done cycle is ignored. The earliest new start is accepted the cycle after done.
- Storage: two WIDTH-bit term registers plus one CNT_W counter.
- out_idx wraps never: it is bounded by num_terms-1 <= 2^CNT_W - 2.

Test Plan:
- WIDTH=32, seeds 0/1, num_terms=10, out_ready=1 -> back-to-back beats 0,1,1,2,3,5,8,13,21,34; out_last only at idx 9; done one cycle after; ovf_sticky=0.
- Seeds 2/1 (Lucas), num_terms=6 -> 2,1,3,4,7,11; then a second start with seeds 0/1, num_terms=3 -> 0,1,1.
- WIDTH=8, seeds 0/1, num_terms=16:
  - idx 13 = 233 with out_ovf=0.
  - idx 14 = 121 with out_ovf=1; ovf_sticky rises with it.
  - idx 15 = 98 with out_ovf=1.
  - ovf_sticky stays 1 after done; it clears on the next start.
- Backpressure: out_ready low 3 cycles at idx 4 (value 3) -> out_data=3, idx=4 held stable; next term 5 appears the cycle after the handshake; start pulses during RUN are ignored.
- num_terms=0 -> no out_valid; done pulses the cycle after start. num_terms=1, seeds 7/9 -> single beat 7 with out_last=1.
- rst asserted at idx 5 -> all outputs 0 the next cycle, no done; a fresh start afterwards yields a correct sequence from idx 0.

Source files
------------

// File: rtl/fib_seq_gen.sv
// Bounded generalised Fibonacci term streamer with valid/ready output.
// Holds only the current and previous term; overflow tracked per beat.
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] n_q;
  logic             valid_q;
  logic             last_q;
  logic             ovf_q;
  logic             sticky_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH:0]   sum_d;
  logic [CNT_W-1:0] idx_d;
  logic             last_d;
  logic             fire;

  assign sum_d  = {1'b0, prev_q} + {1'b0, cur_q};
  assign idx_d  = idx_q + CNT_W'(1);
  assign last_d = (idx_d == (n_q - CNT_W'(1)));
  assign fire   = valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q      <= num_terms;
            cur_q    <= seed0;
            // seed1 parks in prev_q until beat 0 is taken
            prev_q   <= seed1;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b1;
            if (num_terms == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              last_q  <= (num_terms == CNT_W'(1));
            end
          end
        end
        RUN: begin
          if (fire) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_d;
              last_q <= last_d;
              prev_q <= cur_q;
              if (idx_q == '0) begin
                cur_q <= prev_q;
                ovf_q <= 1'b0;
              end else begin
                cur_q <= sum_d[WIDTH-1:0];
                ovf_q <= sum_d[WIDTH];
                if (sum_d[WIDTH]) begin
                  sticky_q <= 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign out_data   = cur_q;
  assign out_idx    = idx_q;
  assign out_last   = last_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;
  assign done       = done_q;

endmodule
